c2f_fabric_rsp: RTL and testbench
=================================

// Module: c2f_fabric_rsp
// PURPOSE
//  Fabric-side responder for the core-to-fabric (C2F) channel of gpc_4t.
//  - Accepts C2F requests (RD/WR) and services them from a local shared-memory model.
//  - Returns one response per request on the C2F response interface, through a response FIFO.
//  - Raises C2F_RspStall as backpressure.
//  - Replaces tied-off C2F response inputs in the gpc_4t bench and acts as the fabric end in ring-less tests.
// PARAMETERS
//  MEM_DEPTH   1024  32-bit words in shared-memory model (power of 2)
//  FIFO_DEPTH  4     response FIFO entries (power of 2, >=4)
//  ADDR_LSB    2     byte-address bit where the word index starts
// PORTS
//  QClk                  in   1   clock, all state on rising edge
//  RstQnnnL              in   1   asynchronous reset, active low
//  C2F_ReqValidQ500H     in   1   request valid
//  C2F_ReqOpcodeQ500H    in   2   00=RD 10=WR (01/11 illegal)
//  C2F_ReqThreadIDQ500H  in   2   issuing thread
//  C2F_ReqAddressQ500H   in   32  byte address
//  C2F_ReqDataQ500H      in   32  write data
//  C2F_RspReadyQ502H     in   1   consumer accepts head response this cycle
//  C2F_RspValidQ502H     out  1   response valid (FIFO non-empty)
//  C2F_RspOpcodeQ502H    out  2   01=RD_RSP 11=WR_RSP
//  C2F_RspThreadIDQ502H  out  2   thread ID echoed from request
//  C2F_RspDataQ502H      out  32  read data (RD); write data echoed (WR)
//  C2F_RspStall          out  1   requester must not issue while high
//  ErrStickyQnnnH        out  1   sticky: dropped or illegal request seen
// BEHAVIOUR
//  Reset (async, RstQnnnL=0)
//   - RspValid, RspOpcode, RspThreadID, RspData, RspStall, ErrSticky, FIFO count/pointers, Q501 valid -> 0.
//   - Memory array is not reset; the bench backdoor-loads `mem`.
//   - Reset mid-operation discards all in-flight requests and queued responses; no response is emitted for them.
//  Pipeline
//   - Q500: request sampled into Q501 register when valid and accepted.
//   - Q501: word index = Address[ADDR_LSB +: log2(MEM_DEPTH)]; upper bits ignored (aliasing).
//     - RD: reads mem.
//     - WR: writes mem at the Q501->Q502 edge.
//     - The response entry is pushed into the FIFO on the same edge.
//   - Q502: FIFO head drives Rsp* outputs. Minimum latency is 2 cycles: request in cycle N -> RspValid in N+2 (FIFO empty).
//  Ordering
//   - Responses are returned strictly in request order, independent of thread.
//   - RD in cycle N+1 to the same word as a WR in cycle N returns the new data.
//  Handshake
//   - Head pops when RspValid & RspReady.
//   - Rsp* outputs are held stable while Valid & !Ready.
//   - Push and pop in the same cycle: count unchanged; a full FIFO may push if popping.
//  Stall
//   - occ = FIFO count + Q501 valid.
//   - RspStall is registered: next = (occ_next >= FIFO_DEPTH-1), which leaves room for one in-flight request.
//  Errors
//   - A request with Valid while RspStall=1 is accepted if space exists, else dropped.
//   - Dropped requests, and requests with an illegal opcode, set ErrSticky.
//   - Illegal opcodes are dropped and produce no response.
//   - ErrSticky clears only on reset.
//  Width
//   - FIFO count is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
// TESTING
//  1. Reset, then RD addr 0x40 with mem[16]=0xDEADBEEF, Ready=1 -> Valid at N+2, op=01, data=DEADBEEF, Valid=0 at N+3.
//  2. WR 0x40 data 0x12345678 tid=2 at N, RD 0x40 tid=3 at N+1 ->
//     - N+2: op=11, tid=2.
//     - N+3: op=01, tid=3, data=12345678.
//  3. Ready=0 with 3 back-to-back RDs -> RspStall=1 once occ>=3; outputs held; Ready=1 drains 3 responses in order, then Stall=0.
//  4. Ready=0 with requests ignoring Stall until full+1 -> 4 responses queued, 5th dropped, ErrSticky=1 and held.
//  5. Opcode 01 request -> no response, ErrSticky=1.
//  6. RstQnnnL low mid-drain with 2 queued -> all outputs 0 asynchronously; after release, a new RD returns at N+2 with no stale entries.

Source files
------------

// File: rtl/c2f_fabric_rsp.sv
// c2f_fabric_rsp
// Fabric-side responder for the core-to-fabric (C2F) channel. Requests are
// captured into a Q501 stage, serviced from a local shared-memory model and
// queued as responses in a small FIFO whose head drives the Q502 outputs.
//
// Ports
//   QClk                  in   clock, all state on rising edge
//   RstQnnnL              in   asynchronous reset, active low
//   C2F_ReqValidQ500H     in   request valid
//   C2F_ReqOpcodeQ500H    in   2'b00 = RD, 2'b10 = WR (others illegal)
//   C2F_ReqThreadIDQ500H  in   issuing thread
//   C2F_ReqAddressQ500H   in   byte address
//   C2F_ReqDataQ500H      in   write data
//   C2F_RspReadyQ502H     in   consumer accepts head response
//   C2F_RspValidQ502H     out  response valid (FIFO non-empty)
//   C2F_RspOpcodeQ502H    out  2'b01 = RD_RSP, 2'b11 = WR_RSP
//   C2F_RspThreadIDQ502H  out  thread ID echoed from request
//   C2F_RspDataQ502H      out  read data (RD) or echoed write data (WR)
//   C2F_RspStall          out  requester must not issue while high
//   ErrStickyQnnnH        out  sticky: dropped or illegal request seen

module c2f_fabric_rsp #(
    parameter int MEM_DEPTH  = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_LSB   = 2
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic        C2F_ReqValidQ500H,
    input  logic [1:0]  C2F_ReqOpcodeQ500H,
    input  logic [1:0]  C2F_ReqThreadIDQ500H,
    input  logic [31:0] C2F_ReqAddressQ500H,
    input  logic [31:0] C2F_ReqDataQ500H,
    input  logic        C2F_RspReadyQ502H,
    output logic        C2F_RspValidQ502H,
    output logic [1:0]  C2F_RspOpcodeQ502H,
    output logic [1:0]  C2F_RspThreadIDQ502H,
    output logic [31:0] C2F_RspDataQ502H,
    output logic        C2F_RspStall,
    output logic        ErrStickyQnnnH
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] RSP_RD = 2'b01;
    localparam logic [1:0] RSP_WR = 2'b11;

    logic [31:0] mem [MEM_DEPTH];

    logic          q501_valid;
    logic          q501_is_wr;
    logic [1:0]    q501_tid;
    logic [IW-1:0] q501_idx;
    logic [31:0]   q501_data;

    logic [1:0]    fifo_op   [FIFO_DEPTH];
    logic [1:0]    fifo_tid  [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          stall_q;
    logic          err_q;

    logic          req_legal;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_after;
    logic          space;
    logic          accept;
    logic          drop;
    logic [OW-1:0] occ_next;
    logic          stall_next;
    logic [31:0]   push_data;
    logic          unused_addr_bits;

    // Address bits outside the word index are deliberately ignored (aliasing).
    assign unused_addr_bits = ^{C2F_ReqAddressQ500H[31:ADDR_LSB+IW],
                                C2F_ReqAddressQ500H[ADDR_LSB-1:0]};

    always_comb begin
        req_legal  = (C2F_ReqOpcodeQ500H == OP_RD) || (C2F_ReqOpcodeQ500H == OP_WR);
        push       = q501_valid;
        pop        = (count != '0) && C2F_RspReadyQ502H;
        // FIFO fill after this edge; a new request is only taken if its push
        // next cycle is guaranteed a slot.
        fifo_after = count + CW'(push) - CW'(pop);
        space      = fifo_after < CW'(FIFO_DEPTH);
        accept     = C2F_ReqValidQ500H && req_legal && space;
        drop       = C2F_ReqValidQ500H && !accept;
        occ_next   = {1'b0, fifo_after} + OW'(accept);
        stall_next = occ_next >= OW'(FIFO_DEPTH - 1);
        push_data  = q501_is_wr ? q501_data : mem[q501_idx];
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            q501_valid <= 1'b0;
            q501_is_wr <= 1'b0;
            q501_tid   <= '0;
            q501_idx   <= '0;
            q501_data  <= '0;
        end else begin
            q501_valid <= accept;
            if (accept) begin
                q501_is_wr <= (C2F_ReqOpcodeQ500H == OP_WR);
                q501_tid   <= C2F_ReqThreadIDQ500H;
                q501_idx   <= C2F_ReqAddressQ500H[ADDR_LSB +: IW];
                q501_data  <= C2F_ReqDataQ500H;
            end
        end
    end

    // A read one cycle behind a write to the same word sees the new data,
    // because the write lands on the edge before the read leaves Q501.
    always_ff @(posedge QClk) begin
        if (q501_valid && q501_is_wr) begin
            mem[q501_idx] <= q501_data;
        end
    end

    always_ff @(posedge QClk) begin
        if (push) begin
            fifo_op[wr_ptr]   <= q501_is_wr ? RSP_WR : RSP_RD;
            fifo_tid[wr_ptr]  <= q501_tid;
            fifo_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= fifo_after;
            stall_q <= stall_next;
            if (drop) begin
                err_q <= 1'b1;
            end
        end
    end

    // Head fields are gated by valid so outputs read zero while empty or in reset.
    always_comb begin
        C2F_RspValidQ502H    = (count != '0);
        C2F_RspOpcodeQ502H   = C2F_RspValidQ502H ? fifo_op[rd_ptr]   : 2'b00;
        C2F_RspThreadIDQ502H = C2F_RspValidQ502H ? fifo_tid[rd_ptr]  : 2'b00;
        C2F_RspDataQ502H     = C2F_RspValidQ502H ? fifo_data[rd_ptr] : 32'h0;
        C2F_RspStall         = stall_q;
        ErrStickyQnnnH       = err_q;
    end

endmodule

// File: tb/tb_c2f_fabric_rsp.sv
module tb_c2f_fabric_rsp;

    logic        QClk = 1'b0;
    logic        RstQnnnL = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [1:0]  req_tid = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic        rsp_ready = 1'b0;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
    logic [1:0]  rsp_tid;
    logic [31:0] rsp_data;
    logic        rsp_stall;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    c2f_fabric_rsp dut (
        .QClk                 (QClk),
        .RstQnnnL             (RstQnnnL),
        .C2F_ReqValidQ500H    (req_valid),
        .C2F_ReqOpcodeQ500H   (req_op),
        .C2F_ReqThreadIDQ500H (req_tid),
        .C2F_ReqAddressQ500H  (req_addr),
        .C2F_ReqDataQ500H     (req_data),
        .C2F_RspReadyQ502H    (rsp_ready),
        .C2F_RspValidQ502H    (rsp_valid),
        .C2F_RspOpcodeQ502H   (rsp_op),
        .C2F_RspThreadIDQ502H (rsp_tid),
        .C2F_RspDataQ502H     (rsp_data),
        .C2F_RspStall         (rsp_stall),
        .ErrStickyQnnnH       (err)
    );

    always #5 QClk = ~QClk;

    // Monitor: every accepted response must match the oldest expected entry.
    always @(negedge QClk) begin
        if (rsp_valid && rsp_ready) begin
            logic [35:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got op=%0h tid=%0d data=%08h, expected none",
                         rsp_op, rsp_tid, rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_op, rsp_tid, rsp_data} !== e) begin
                    errors++;
                    $display("FAIL rsp_order got op=%0h tid=%0d data=%08h, expected op=%0h tid=%0d data=%08h",
                             rsp_op, rsp_tid, rsp_data, e[35:34], e[33:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge QClk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", name, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] tid,
                        input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_tid   = tid;
        req_addr  = addr;
        req_data  = data;
        tick();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_tid   = 2'b00;
        req_addr  = 32'h0;
        req_data  = 32'h0;
    endtask

    task automatic expect_rsp(input logic [1:0] op, input logic [1:0] tid, input logic [31:0] data);
        exp_q.push_back({op, tid, data});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_op"},    32'(rsp_op),    32'h0);
        chk({tag, "_tid"},   32'(rsp_tid),   32'h0);
        chk({tag, "_data"},  rsp_data,       32'h0);
        chk({tag, "_stall"}, 32'(rsp_stall), 32'h0);
        chk({tag, "_err"},   32'(err),       32'h0);
    endtask

    // Called at posedge+1; reset assert and release both fall between edges.
    task automatic do_reset(input string tag);
        RstQnnnL = 1'b0;
        #2;
        chk_all_zero(tag);
        #5;
        RstQnnnL = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        #2;
        RstQnnnL = 1'b0;
        #10;
        chk_all_zero("reset0");
        RstQnnnL = 1'b1;
        tick();

        // Preload mem[16] through the interface; memory survives reset.
        rsp_ready = 1'b1;
        expect_rsp(2'b11, 2'd0, 32'hDEADBEEF);
        send(2'b10, 2'd0, 32'h40, 32'hDEADBEEF);
        idle();
        wait_cyc(4);
        do_reset("reset1");

        // Test 1: RD latency N+2, one-cycle valid with Ready=1.
        expect_rsp(2'b01, 2'd1, 32'hDEADBEEF);
        send(2'b00, 2'd1, 32'h40, 32'h0);
        idle();
        chk("t1_valid_n1", 32'(rsp_valid), 32'h0);
        tick();
        chk("t1_valid_n2", 32'(rsp_valid), 32'h1);
        chk("t1_op",       32'(rsp_op),    32'h1);
        chk("t1_data",     rsp_data,       32'hDEADBEEF);
        tick();
        chk("t1_valid_n3", 32'(rsp_valid), 32'h0);

        // Test 2: WR then RD to the same word on consecutive cycles.
        expect_rsp(2'b11, 2'd2, 32'h12345678);
        expect_rsp(2'b01, 2'd3, 32'h12345678);
        send(2'b10, 2'd2, 32'h40, 32'h12345678);
        send(2'b00, 2'd3, 32'h40, 32'h0);
        idle();
        chk("t2_op_n2",   32'(rsp_op),  32'h3);
        chk("t2_tid_n2",  32'(rsp_tid), 32'h2);
        tick();
        chk("t2_op_n3",   32'(rsp_op),  32'h1);
        chk("t2_tid_n3",  32'(rsp_tid), 32'h3);
        chk("t2_data_n3", rsp_data,     32'h12345678);
        tick();

        // Test 3: backpressure, stall threshold, held outputs, aliased read.
        expect_rsp(2'b11, 2'd0, 32'hAAAA0001);
        expect_rsp(2'b11, 2'd1, 32'hBBBB0002);
        send(2'b10, 2'd0, 32'h80, 32'hAAAA0001);
        send(2'b10, 2'd1, 32'h84, 32'hBBBB0002);
        idle();
        wait_cyc(4);
        rsp_ready = 1'b0;
        expect_rsp(2'b01, 2'd0, 32'hAAAA0001);
        expect_rsp(2'b01, 2'd1, 32'hBBBB0002);
        expect_rsp(2'b01, 2'd2, 32'h12345678);
        send(2'b00, 2'd0, 32'h80, 32'h0);
        send(2'b00, 2'd1, 32'h84, 32'h0);
        chk("t3_stall_occ2", 32'(rsp_stall), 32'h0);
        send(2'b00, 2'd2, 32'h1040, 32'h0);
        idle();
        chk("t3_stall_occ3", 32'(rsp_stall), 32'h1);
        wait_cyc(2);
        chk("t3_hold_valid", 32'(rsp_valid), 32'h1);
        chk("t3_hold_tid",   32'(rsp_tid),   32'h0);
        chk("t3_hold_data",  rsp_data,       32'hAAAA0001);
        tick();
        chk("t3_hold_data2", rsp_data,       32'hAAAA0001);
        rsp_ready = 1'b1;
        wait_cyc(5);
        chk("t3_drained_valid", 32'(rsp_valid), 32'h0);
        chk("t3_drained_stall", 32'(rsp_stall), 32'h0);

        // Test 4: overfill ignoring stall; fifth request dropped.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_rsp(2'b01, 2'(i), 32'hBBBB0002);
            send(2'b00, 2'(i), 32'h84, 32'h0);
            if (i == 3) chk("t4_err_before_drop", 32'(err), 32'h0);
        end
        idle();
        chk("t4_err_after_drop", 32'(err), 32'h1);
        wait_cyc(3);
        chk("t4_err_held",  32'(err),       32'h1);
        chk("t4_stall_full", 32'(rsp_stall), 32'h1);
        rsp_ready = 1'b1;
        wait_cyc(6);
        chk("t4_drained_valid", 32'(rsp_valid), 32'h0);
        chk("t4_err_sticky",    32'(err),       32'h1);

        do_reset("reset2");

        // Test 5: illegal opcodes produce no response and set the sticky error.
        send(2'b01, 2'd1, 32'h80, 32'h0);
        idle();
        chk("t5_err_set", 32'(err), 32'h1);
        send(2'b11, 2'd2, 32'h80, 32'h0);
        idle();
        wait_cyc(3);
        chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
        expect_rsp(2'b01, 2'd2, 32'hAAAA0001);
        send(2'b00, 2'd2, 32'h80, 32'h0);
        idle();
        wait_cyc(3);

        do_reset("reset3");

        // Test 6: reset mid-drain discards queued responses.
        rsp_ready = 1'b0;
        expect_rsp(2'b01, 2'd0, 32'hAAAA0001);
        expect_rsp(2'b01, 2'd1, 32'hBBBB0002);
        send(2'b00, 2'd0, 32'h80, 32'h0);
        send(2'b00, 2'd1, 32'h84, 32'h0);
        idle();
        wait_cyc(2);
        chk("t6_queued_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        tick();
        #1;
        RstQnnnL = 1'b0;
        #1;
        chk_all_zero("t6_async");
        exp_q.delete();
        #4;
        RstQnnnL = 1'b1;
        tick();
        expect_rsp(2'b01, 2'd3, 32'hBBBB0002);
        send(2'b00, 2'd3, 32'h84, 32'h0);
        idle();
        chk("t6_valid_n1", 32'(rsp_valid), 32'h0);
        tick();
        chk("t6_valid_n2", 32'(rsp_valid), 32'h1);
        chk("t6_tid_n2",   32'(rsp_tid),   32'h3);
        chk("t6_data_n2",  rsp_data,       32'hBBBB0002);
        tick();
        chk("t6_valid_n3", 32'(rsp_valid), 32'h0);

        wait_cyc(2);
        chk("all_rsp_seen", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
